lsu_byte_serial: RTL and testbench
==================================

LSU_BYTE_SERIAL -- requirements
Module: lsu_byte_serial

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset:
- clk: input, 1 bit, sole clock; all state updates on the rising edge.
- rst: input, 1 bit, synchronous, active-high reset.
REQ-002 SHALL have these CPU-side ports:
- mem_read: input, 3 bits; 000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU; 110/111 treated as none.
- mem_write: input, 2 bits; 00 none, 01 SW, 10 SH, 11 SB.
- addr: input, 32 bits, byte address from the ALU.
- wdata: input, 32 bits, store data (rs2).
- rdata: output, 32 bits, extended load result.
- stall: output, 1 bit, freezes PC and register-file write while high.
- misalign: output, 1 bit, misaligned-access flag.
- bus_err: output, 1 bit, timeout flag.
REQ-003 SHALL have these byte-memory-side ports:
- mb_addr: output, 32 bits.
- mb_wdata: output, 8 bits.
- mb_re: output, 1 bit.
- mb_we: output, 1 bit.
- mb_rdata: input, 8 bits.
- mb_ready: input, 1 bit, beat-complete strobe.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-005 Request present = (mem_read in 001..101) or (mem_write != 00); if both are nonzero, the read SHALL be executed and the write ignored.
REQ-006 Beat count SHALL be 4 for word, 2 for half, 1 for byte.
REQ-007 Byte k of the access SHALL use mb_addr = addr + k, k = 0..N-1, little-endian; the sum wraps modulo 2^32.
REQ-008 stall SHALL be combinational: high in IDLE when a request is present, high throughout ACCESS, low in DONE and in IDLE with no request.
REQ-009 IDLE with an aligned request SHALL latch operation, addr and wdata, clear the beat index, and go to ACCESS next cycle.
REQ-010 IDLE with a misaligned request SHALL go directly to DONE with misalign=1, rdata=0 and no bus beat.
- word: addr[1:0] != 00.
- half: addr[0] != 0.
REQ-011 In ACCESS, exactly one of mb_re/mb_we SHALL be high, with mb_addr for the current beat and mb_wdata = wdata byte k (0 during reads).
REQ-012 A beat SHALL complete on a cycle where mb_ready=1 is sampled; read byte k is captured from mb_rdata into buffer byte k on that edge.
REQ-013 The beat index SHALL advance on each completed beat; the last completed beat SHALL transition to DONE.
REQ-014 mb_re/mb_we SHALL be low in IDLE and DONE.
REQ-015 A 4-bit wait counter SHALL reset on each beat start and increment each ACCESS cycle with mb_ready=0.
REQ-016 When the wait counter reaches 15, the FSM SHALL abort to DONE with bus_err=1, rdata=0, and not issue the remaining beats.
REQ-017 DONE SHALL last exactly one cycle, then go unconditionally to IDLE; misalign and bus_err are valid only in DONE and 0 elsewhere.
REQ-018 rdata in DONE SHALL be formed as follows, and SHALL be 0 outside DONE and for stores:
- LW: buffer[31:0].
- LH: sign-extended buffer[15:0].
- LHU: zero-extended buffer[15:0].
- LB: sign-extended buffer[7:0].
- LBU: zero-extended buffer[7:0].
REQ-019 The CPU holds mem_read, mem_write, addr and wdata stable while stall=1; the block SHALL use only the values latched in IDLE.
REQ-020 Minimum latency SHALL be N+2 cycles (IDLE accept, N beats, DONE) with mb_ready tied high.

Reset
REQ-021 While rst=1 the FSM SHALL enter IDLE on the next edge.
REQ-022 While rst=1 the buffer, beat index, wait counter and latched request SHALL clear to 0.
REQ-023 After reset, outputs SHALL be:
- mb_re=0, mb_we=0, mb_addr=0, mb_wdata=0.
- rdata=0, misalign=0, bus_err=0.
- stall driven per REQ-008 from the current inputs.
REQ-024 Reset asserted mid-ACCESS SHALL abandon the transaction with no further beats; the memory must tolerate a partial store.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- LW, addr=0x100, mb_ready=1, bytes 0x78,0x56,0x34,0x12 -> beats at 0x100..0x103, 6-cycle stall window ending with DONE, rdata=0x12345678.
- LB, addr=0x203, byte 0x80 -> rdata=0xFFFFFF80; LBU with the same byte -> 0x00000080.
- SH, addr=0x0E, wdata=0xAABBCCDD, mb_ready delayed 3 cycles per beat -> mb_we at 0x0E (0xDD) then 0x0F (0xCC), no read strobes.
- SW, addr=0x102 -> no mb_we, DONE next cycle with misalign=1; LH at 0x101 likewise.
- LW with mb_ready stuck 0 -> bus_err=1 in DONE after 15 wait cycles, rdata=0, then IDLE.
- rst=1 during beat 2 of SW -> next cycle IDLE, mb_we=0, and a new LB completes normally.

Source files
------------

// File: rtl/lsu_byte_serial_if.sv
// Byte-wide memory port of the serial LSU: one beat per mb_ready strobe.
interface lsu_byte_serial_if;
    logic [31:0] mb_addr;
    logic [7:0]  mb_wdata;
    logic        mb_re;
    logic        mb_we;
    logic [7:0]  mb_rdata;
    logic        mb_ready;

    modport master (
        output mb_addr, mb_wdata, mb_re, mb_we,
        input  mb_rdata, mb_ready
    );

    modport slave (
        input  mb_addr, mb_wdata, mb_re, mb_we,
        output mb_rdata, mb_ready
    );
endinterface

// File: rtl/lsu_byte_serial.sv
// Load/store unit that serialises word/half/byte accesses into little-endian
// byte beats on an 8-bit memory port, with alignment and timeout checking.
module lsu_byte_serial (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mem_read,
    input  logic [1:0]         mem_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               misalign,
    output logic               bus_err,
    lsu_byte_serial_if.master  mem
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  state;
    logic        rd_req, wr_req, req, req_misalign;
    logic [1:0]  req_size;
    logic        read_q;
    logic [2:0]  op_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, data_buf;
    logic [1:0]  beat, last_beat;
    logic [3:0]  wait_cnt;
    logic        misalign_q, bus_err_q;

    function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [31:0] data);
        logic signed [15:0] half_s;
        logic signed [7:0]  byte_s;
        half_s = data[15:0];
        byte_s = data[7:0];
        case (op)
            3'b001:  return data;
            3'b010:  return 32'(half_s);
            3'b011:  return {16'd0, data[15:0]};
            3'b100:  return 32'(byte_s);
            3'b101:  return {24'd0, data[7:0]};
            default: return 32'd0;
        endcase
    endfunction

    // A read wins over a simultaneous write; codes 110/111 are not reads.
    always_comb begin
        rd_req = (mem_read >= 3'd1) && (mem_read <= 3'd5);
        wr_req = (mem_write != 2'd0);
        req    = rd_req || wr_req;
        req_size = SZ_BYTE;
        if (rd_req) begin
            case (mem_read)
                3'b001:         req_size = SZ_WORD;
                3'b010, 3'b011: req_size = SZ_HALF;
                default:        req_size = SZ_BYTE;
            endcase
        end else begin
            case (mem_write)
                2'b01:   req_size = SZ_WORD;
                2'b10:   req_size = SZ_HALF;
                default: req_size = SZ_BYTE;
            endcase
        end
        req_misalign = ((req_size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                       ((req_size == SZ_HALF) && addr[0]);
        last_beat = (size_q == SZ_WORD) ? 2'd3 :
                    (size_q == SZ_HALF) ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            read_q     <= 1'b0;
            op_q       <= 3'd0;
            size_q     <= SZ_BYTE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            data_buf   <= 32'd0;
            beat       <= 2'd0;
            wait_cnt   <= 4'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    misalign_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                    if (req) begin
                        if (req_misalign) begin
                            state      <= DONE;
                            misalign_q <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            read_q   <= rd_req;
                            op_q     <= mem_read;
                            size_q   <= req_size;
                            addr_q   <= addr;
                            wdata_q  <= wdata;
                            beat     <= 2'd0;
                            wait_cnt <= 4'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem.mb_ready) begin
                        wait_cnt <= 4'd0;
                        if (read_q)
                            data_buf[{beat, 3'b000} +: 8] <= mem.mb_rdata;
                        beat <= beat + 2'd1;
                        if (beat == last_beat)
                            state <= DONE;
                    end else if (wait_cnt == 4'd14) begin
                        // Fifteenth idle cycle of this beat: give up on the rest.
                        wait_cnt  <= 4'd15;
                        bus_err_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    misalign_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall        = (state == ACCESS) || ((state == IDLE) && req);
        mem.mb_re    = (state == ACCESS) && read_q;
        mem.mb_we    = (state == ACCESS) && !read_q;
        mem.mb_addr  = (state == ACCESS) ? addr_q + {30'd0, beat} : 32'd0;
        mem.mb_wdata = ((state == ACCESS) && !read_q) ? wdata_q[{beat, 3'b000} +: 8] : 8'd0;
        misalign     = (state == DONE) && misalign_q;
        bus_err      = (state == DONE) && bus_err_q;
        rdata        = ((state == DONE) && read_q && !misalign_q && !bus_err_q) ?
                       extend_load(op_q, data_buf) : 32'd0;
    end
endmodule

// File: tb/tb_lsu_byte_serial.sv
// Randomised bench for lsu_byte_serial against a byte-array memory model.
module tb_lsu_byte_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        stall, misalign, bus_err;

    lsu_byte_serial_if mbus();

    lsu_byte_serial dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .mem      (mbus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_arr [logic [31:0]];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    // One CPU request from issue to the first IDLE cycle after it; called at negedge+1.
    task automatic run_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input bit stuck,
                           input int rst_beat, output logic [31:0] got);
        bit is_rd, is_wr, mis, done_seen, rdy;
        int nb, k, wt, stall_cnt, exp_cycles, exp_beats;
        logic [31:0] val, exp_rd;
        got = 32'd0;
        is_rd = (rd >= 3'd1) && (rd <= 3'd5);
        is_wr = !is_rd && (wr != 2'd0);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        if (!is_rd && !is_wr) begin
            mbus.mb_ready = 1'b1;
            #1;
            check_val("noreq_stall", {stall, mbus.mb_re, mbus.mb_we}, 0);
            @(negedge clk); #1;
            check_val("noreq_quiet", {stall, mbus.mb_re, mbus.mb_we, rdata}, 0);
            mem_read = 3'd0; mem_write = 2'd0; mbus.mb_ready = 1'b0;
            return;
        end
        if ((is_rd && rd == 3'd1) || (!is_rd && wr == 2'd1)) nb = 4;
        else if ((is_rd && rd <= 3'd3) || (!is_rd && wr == 2'd2)) nb = 2;
        else nb = 1;
        mis = (nb == 4 && a[1:0] != 2'b00) || (nb == 2 && a[0]);
        val = 32'd0;
        for (int i = 0; i < nb; i++) val = val | (32'(mem_byte(a + i)) << (8 * i));
        case (rd)
            3'd1:    exp_rd = val;
            3'd2:    exp_rd = (val >= 32'h8000) ? val + 32'hFFFF0000 : val;
            3'd3:    exp_rd = val;
            3'd4:    exp_rd = (val >= 32'h80) ? val + 32'hFFFFFF00 : val;
            3'd5:    exp_rd = val;
            default: exp_rd = 32'd0;
        endcase
        if (!is_rd || mis || stuck) exp_rd = 32'd0;
        exp_cycles = mis ? 1 : (stuck ? 16 : 1 + nb * (dly + 1));
        exp_beats  = (mis || stuck) ? 0 : nb;

        #1;
        done_seen = 1'b0; stall_cnt = 0; k = 0; wt = 0;
        for (int c = 0; c < 64 && !done_seen; c++) begin
            if (!stall) begin
                done_seen = 1'b1;
            end else begin
                stall_cnt++;
                check_val("busy_out", {rdata, misalign, bus_err}, 0);
                if (mbus.mb_re || mbus.mb_we) begin
                    check_val("beat_re", mbus.mb_re, is_rd);
                    check_val("beat_we", mbus.mb_we, !is_rd);
                    check_val("beat_addr", mbus.mb_addr, a + k);
                    check_val("beat_wdata", mbus.mb_wdata, is_rd ? 8'd0 : 8'(wd >> (8 * k)));
                    if (k == rst_beat) begin
                        rst = 1'b1; mem_read = 3'd0; mem_write = 2'd0; mbus.mb_ready = 1'b0;
                        @(negedge clk); #1;
                        check_val("rst_abort_ctl", {stall, mbus.mb_re, mbus.mb_we, misalign, bus_err}, 0);
                        check_val("rst_abort_bus", {mbus.mb_addr, mbus.mb_wdata}, 0);
                        check_val("rst_abort_rdata", rdata, 0);
                        rst = 1'b0;
                        return;
                    end
                    rdy = !stuck && (wt >= dly);
                    mbus.mb_ready = rdy;
                    mbus.mb_rdata = rdy ? mem_byte(a + k) : 8'($urandom);
                    if (rdy) begin
                        if (!is_rd) mem_arr[a + k] = 8'(wd >> (8 * k));
                        k++;
                        wt = 0;
                    end else begin
                        wt++;
                    end
                end else begin
                    mbus.mb_ready = 1'($urandom);
                    mbus.mb_rdata = 8'($urandom);
                end
            end
            if (!done_seen) begin
                @(negedge clk); #1;
            end
        end
        check_val("done_reached", done_seen, 1);
        if (done_seen) begin
            got = rdata;
            check_val("rdata", rdata, exp_rd);
            check_val("misalign", misalign, mis);
            check_val("bus_err", bus_err, stuck && !mis);
            check_val("stall_cycles", stall_cnt, exp_cycles);
            check_val("beats", k, exp_beats);
            check_val("done_strobes", {mbus.mb_re, mbus.mb_we}, 0);
        end
        mem_read = 3'd0; mem_write = 2'd0; mbus.mb_ready = 1'b0;
        @(negedge clk); #1;
        check_val("idle_after", {stall, mbus.mb_re, mbus.mb_we, misalign, bus_err, rdata}, 0);
    endtask

    initial begin
        logic [31:0] got, a;
        logic [2:0]  rd;
        logic [1:0]  wr;
        rst = 1'b1; mem_read = 3'd0; mem_write = 2'd0; addr = 32'd0; wdata = 32'd0;
        mbus.mb_ready = 1'b0; mbus.mb_rdata = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ctl", {stall, mbus.mb_re, mbus.mb_we, misalign, bus_err}, 0);
        check_val("rst_bus", {mbus.mb_addr, mbus.mb_wdata}, 0);
        check_val("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        mem_arr[32'h100] = 8'h78; mem_arr[32'h101] = 8'h56;
        mem_arr[32'h102] = 8'h34; mem_arr[32'h103] = 8'h12;
        run_txn(3'b001, 2'b00, 32'h100, 32'd0, 0, 1'b0, -1, got);
        check_val("lw_value", got, 32'h12345678);

        mem_arr[32'h203] = 8'h80;
        run_txn(3'b100, 2'b00, 32'h203, 32'd0, 0, 1'b0, -1, got);
        check_val("lb_sext", got, 32'hFFFFFF80);
        run_txn(3'b101, 2'b00, 32'h203, 32'd0, 1, 1'b0, -1, got);
        check_val("lbu_zext", got, 32'h00000080);

        run_txn(3'b000, 2'b10, 32'h0E, 32'hAABBCCDD, 3, 1'b0, -1, got);
        run_txn(3'b011, 2'b00, 32'h0E, 32'd0, 0, 1'b0, -1, got);
        check_val("sh_readback", got, 32'h0000CCDD);

        run_txn(3'b000, 2'b01, 32'h102, 32'h11223344, 0, 1'b0, -1, got);
        run_txn(3'b010, 2'b00, 32'h101, 32'd0, 0, 1'b0, -1, got);
        check_val("lh_misalign_rdata", got, 32'd0);

        run_txn(3'b001, 2'b00, 32'h100, 32'd0, 0, 1'b1, -1, got);
        check_val("lw_timeout_rdata", got, 32'd0);

        run_txn(3'b000, 2'b01, 32'h40, 32'hDEADBEEF, 0, 1'b0, 1, got);
        run_txn(3'b100, 2'b00, 32'h40, 32'd0, 0, 1'b0, -1, got);
        check_val("lb_after_rst", got, 32'hFFFFFFEF);

        for (int n = 0; n < 60; n++) begin
            rd = 3'($urandom_range(0, 7));
            wr = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) != 0 ? 32'hFFFFFFC0 : 32'h00000300) + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(rd, wr, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 15) == 0, -1, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
